// File: rtl/k_low_pass_filter_mc.sv
// N_CH-channel first-order IIR low-pass with unity DC gain, run-time k, seeding, bypass, saturation.
// Latency: a sample driven in cycle t appears on y with out_valid after the edge ending cycle t+1.
// Backpressure: none; one sample per cycle per channel, enable low simply stops acceptance.
module k_low_pass_filter_mc #(
    parameter int                     N_CH       = 4,
    parameter int                     DW         = 16,
    parameter int                     FRAC       = 32,
    parameter int                     K_DEFAULT  = 26,
    parameter int                     K_MIN      = 2,
    parameter int                     K_MAX      = 40,
    parameter logic signed [DW-1:0]   INIT_VALUE = 16'sd8192
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [N_CH*DW-1:0]   x,
    input  logic [5:0]           k_sel,
    input  logic                 k_load,
    input  logic                 seed_en,
    input  logic                 rearm,
    input  logic                 bypass,
    output logic [N_CH*DW-1:0]   y,
    output logic                 out_valid,
    output logic [5:0]           k_act,
    output logic                 k_err
);

    localparam int AW = DW + FRAC;
    localparam int IW = AW + 2;
    localparam logic [5:0] K_MIN6 = 6'(K_MIN);
    localparam logic [5:0] K_MAX6 = 6'(K_MAX);
    localparam logic [5:0] K_DEF6 = 6'(K_DEFAULT);
    localparam logic signed [AW-1:0] INIT_ACC = {INIT_VALUE, {FRAC{1'b0}}};

    logic                 accept;
    logic [5:0]           k_clamped;
    logic                 k_bad;

    logic                 v_s1;
    logic [N_CH*DW-1:0]   x_s1;
    logic                 bypass_s1;
    logic [N_CH-1:0]      seed_s1;
    logic [5:0]           k_s1;

    logic signed [AW-1:0] x_1 [N_CH];
    logic signed [AW-1:0] y_1 [N_CH];
    logic [N_CH-1:0]      primed;

    logic signed [IW-1:0] xf_w  [N_CH];
    logic signed [IW-1:0] w_w   [N_CH];
    logic signed [AW-1:0] xf_a  [N_CH];
    logic signed [AW-1:0] w_sat [N_CH];

    assign accept = enable & in_valid;

    always_comb begin
        k_bad     = (k_sel < K_MIN6) || (k_sel > K_MAX6);
        k_clamped = k_sel;
        if (k_sel < K_MIN6)
            k_clamped = K_MIN6;
        else if (k_sel > K_MAX6)
            k_clamped = K_MAX6;
    end

    // Two guard bits above AW keep the recursion exact before the clamp.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            xf_w[c] = IW'(signed'(x_s1[c*DW +: DW])) <<< FRAC;
            xf_a[c] = xf_w[c][AW-1:0];
            w_w[c]  = IW'(y_1[c])
                    + ((xf_w[c] + IW'(x_1[c])) >>> k_s1)
                    - (IW'(y_1[c]) >>> (k_s1 - 6'd1));
            if (w_w[c][IW-1:AW-1] == 3'b000 || w_w[c][IW-1:AW-1] == 3'b111)
                w_sat[c] = w_w[c][AW-1:0];
            else if (w_w[c][IW-1])
                w_sat[c] = {1'b1, {(AW-1){1'b0}}};
            else
                w_sat[c] = {1'b0, {(AW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_act     <= K_DEF6;
            k_err     <= 1'b0;
            v_s1      <= 1'b0;
            x_s1      <= '0;
            bypass_s1 <= 1'b0;
            seed_s1   <= '0;
            k_s1      <= K_DEF6;
            primed    <= '0;
            out_valid <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                x_1[c]          <= INIT_ACC;
                y_1[c]          <= INIT_ACC;
                y[c*DW +: DW]   <= INIT_VALUE;
            end
        end else begin
            if (k_load) begin
                k_act <= k_clamped;
                if (k_bad)
                    k_err <= 1'b1;
            end

            v_s1 <= accept;
            if (accept) begin
                x_s1      <= x;
                bypass_s1 <= bypass;
                k_s1      <= k_load ? k_clamped : k_act;
                for (int c = 0; c < N_CH; c++)
                    seed_s1[c] <= seed_en & (~primed[c] | rearm);
            end

            out_valid <= v_s1;
            if (rearm)
                primed <= '0;

            // Bypass still advances the filter state so filtering resumes without a glitch.
            if (v_s1) begin
                for (int c = 0; c < N_CH; c++) begin
                    x_1[c] <= xf_a[c];
                    if (seed_s1[c]) begin
                        y_1[c]        <= xf_a[c];
                        y[c*DW +: DW] <= x_s1[c*DW +: DW];
                        primed[c]     <= 1'b1;
                    end else begin
                        y_1[c]        <= w_sat[c];
                        y[c*DW +: DW] <= bypass_s1 ? x_s1[c*DW +: DW] : w_sat[c][AW-1:FRAC];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_k_low_pass_filter_mc.sv
// Directed bench for k_low_pass_filter_mc: reset, DC hold, step, k clamp, seeding, bypass, saturation.
module tb_k_low_pass_filter_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic [63:0] x;
    logic [5:0]  k_sel;
    logic        k_load;
    logic        seed_en;
    logic        rearm;
    logic        bypass;
    logic [63:0] y;
    logic        out_valid;
    logic [5:0]  k_act;
    logic        k_err;

    int checks   = 0;
    int failures = 0;

    k_low_pass_filter_mc dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .x         (x),
        .k_sel     (k_sel),
        .k_load    (k_load),
        .seed_en   (seed_en),
        .rearm     (rearm),
        .bypass    (bypass),
        .y         (y),
        .out_valid (out_valid),
        .k_act     (k_act),
        .k_err     (k_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic signed [15:0] ych(input int c);
        ych = y[c*16 +: 16];
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        k_load   = 1'b0;
        seed_en  = 1'b0;
        rearm    = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int c = 0; c < 4; c++)
            x[c*16 +: 16] = 16'(v);
    endtask

    task automatic set_ch(input int v0, input int v1, input int v2, input int v3);
        x[15:0]  = 16'(v0);
        x[31:16] = 16'(v1);
        x[47:32] = 16'(v2);
        x[63:48] = 16'(v3);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        k_sel  = 6'd0;
        x      = '0;
        idle();
        tick();

        // Reset values
        check("rst_out_valid", out_valid, 0);
        check("rst_y0", ych(0), 8192);
        check("rst_y3", ych(3), 8192);
        check("rst_k_act", k_act, 26);
        check("rst_k_err", k_err, 0);
        reset = 1'b0;
        tick();

        // DC hold: 100 back-to-back samples of 8192 at k=26
        set_all(8192);
        for (int i = 0; i <= 100; i++) begin
            in_valid = (i < 100);
            tick();
            if (i >= 1) begin
                check("dc_out_valid", out_valid, 1);
                check("dc_y", y, {4{16'd8192}});
            end else begin
                check("dc_first_out_valid", out_valid, 0);
            end
        end
        idle();
        tick();
        check("dc_tail_out_valid", out_valid, 0);

        // Step to 9192 with k=2 loaded on the same cycle as the first sample
        do_reset();
        set_all(9192);
        in_valid = 1'b1;
        k_load   = 1'b1;
        k_sel    = 6'd2;
        tick();
        k_load = 1'b0;
        tick();
        check("step_out_valid", out_valid, 1);
        check("step_k_act", k_act, 2);
        check("step_y0_1", ych(0), 8442);
        check("step_y2_1", ych(2), 8442);
        tick();
        check("step_y0_2", ych(0), 8817);
        tick();
        check("step_y0_3", ych(0), 9004);
        idle();
        tick();
        check("step_y0_4", ych(0), 9098);
        tick();
        check("step_idle_out_valid", out_valid, 0);

        // k clamping and sticky error
        k_load = 1'b1;
        k_sel  = 6'd0;
        tick();
        check("kclamp_low", k_act, 2);
        check("kclamp_err_low", k_err, 1);
        k_sel = 6'd63;
        tick();
        check("kclamp_high", k_act, 40);
        k_sel = 6'd10;
        tick();
        check("kclamp_legal", k_act, 10);
        check("kclamp_err_sticky", k_err, 1);
        k_load = 1'b0;
        do_reset();
        check("kclamp_err_cleared", k_err, 0);
        check("kclamp_k_default", k_act, 26);

        // Seeding
        set_ch(1000, -500, 32767, -32768);
        seed_en  = 1'b1;
        in_valid = 1'b1;
        tick();
        seed_en = 1'b0;
        tick();
        check("seed_y0", ych(0), 1000);
        check("seed_y1", ych(1), -500);
        check("seed_y2", ych(2), 32767);
        check("seed_y3", ych(3), -32768);
        idle();
        tick();
        check("seed_hold_y0", ych(0), 1000);
        check("seed_hold_y1", ych(1), -500);
        tick();
        set_ch(2000, -500, 32767, -32768);
        seed_en  = 1'b1;
        in_valid = 1'b1;
        tick();
        idle();
        tick();
        check("seed_primed_y0", ych(0), 1000);
        tick();
        set_ch(2000, 300, 32767, -32768);
        rearm    = 1'b1;
        seed_en  = 1'b1;
        in_valid = 1'b1;
        tick();
        idle();
        tick();
        check("rearm_y0", ych(0), 2000);
        check("rearm_y1", ych(1), 300);

        // enable low blocks acceptance
        enable   = 1'b0;
        set_all(0);
        in_valid = 1'b1;
        tick();
        tick();
        check("enable_low_out_valid", out_valid, 0);
        check("enable_low_y0", ych(0), 2000);
        idle();
        enable = 1'b1;

        // Bypass then seamless return to filtering
        do_reset();
        set_all(1234);
        bypass   = 1'b1;
        in_valid = 1'b1;
        tick();
        bypass = 1'b0;
        tick();
        check("bypass_y0", ych(0), 1234);
        check("bypass_y3", ych(3), 1234);
        idle();
        tick();
        check("bypass_resume_y0", ych(0), 8191);

        // Full-scale swings at k=2 stay in range without sign wrap
        do_reset();
        set_all(32767);
        k_load   = 1'b1;
        k_sel    = 6'd2;
        seed_en  = 1'b1;
        in_valid = 1'b1;
        tick();
        k_load  = 1'b0;
        seed_en = 1'b0;
        set_all(-32768);
        tick();
        check("sat_y_1", ych(0), 32767);
        tick();
        check("sat_y_2", ych(1), 16383);
        idle();
        tick();
        check("sat_y_3", ych(2), -8193);

        // Reset while a sample is in flight
        set_all(5000);
        k_load   = 1'b1;
        k_sel    = 6'd5;
        in_valid = 1'b1;
        tick();
        idle();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y0", ych(0), 8192);
        check("midrst_k_act", k_act, 26);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_after_out_valid", out_valid, 0);
        check("midrst_after_y0", ych(0), 8192);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
